// File: rtl/code_check_pkg.sv
// rtl/code_check_pkg.sv - shared types and constants for the button-code checker
package code_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

    typedef logic [1:0] symbol_t;

    localparam symbol_t SYM_BTN0 = 2'b00;
    localparam symbol_t SYM_BTN1 = 2'b01;
    localparam symbol_t SYM_BTN2 = 2'b10;

    localparam int NUM_SYMBOLS = 4;

    // Symbol idx of a packed 4-symbol code; symbol i lives at [2i+1:2i].
    function automatic symbol_t get_symbol(input logic [7:0] code, input logic [1:0] idx);
        case (idx)
            2'd0:    return code[1:0];
            2'd1:    return code[3:2];
            2'd2:    return code[5:4];
            default: return code[7:6];
        endcase
    endfunction

endpackage

// File: rtl/code_check_ctrl_cycle_timer.sv
// rtl/code_check_ctrl_cycle_timer.sv - 32-bit cycle counter with clear and limit compare
module cycle_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count;

    // Free-running count, restarted from zero whenever the owner clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign expired = (count == (limit - 32'd1));

endmodule

// File: rtl/code_check_ctrl.sv
// rtl/code_check_ctrl.sv - sequences one 4-symbol code entry and its early-exit check
module code_check_ctrl
    import code_check_pkg::*;
#(
    parameter logic [7:0]  SECRET         = 8'b10_01_00_10,
    parameter logic [31:0] CHECK_CYCLES   = 32'd1_000_000,
    parameter logic [31:0] HOLD_CYCLES    = 32'd100_000_000,
    parameter logic [1:0]  MAX_ATTEMPTS   = 2'd3,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        rx_done,
    input  logic [7:0]  rx_code,
    output logic        rx_clear,
    output logic        busy,
    output logic        unlock,
    output logic        fail,
    output logic        locked,
    output logic [2:0]  match_count,
    output logic [31:0] check_time,
    output logic [1:0]  fail_count
);

    localparam logic [1:0] LAST_SYM = 2'(NUM_SYMBOLS - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  code_q;
    logic [1:0]  sym_idx;
    logic [31:0] timer_limit;
    logic        timer_clear;
    logic        timer_expired;
    logic        sym_match;
    logic        load_code;
    logic        advance;
    logic        enter_pass;
    logic        enter_fail;
    logic        lock_done;

    // The comparison walks the code one symbol per CHECK_CYCLES and stops at the
    // first mismatch, so check latency reveals the number of leading matches.
    assign sym_match = (get_symbol(code_q, sym_idx) == get_symbol(SECRET, sym_idx));

    // The single timer restarts on every state change and on every symbol step.
    assign timer_clear = (state_next != state) || advance;

    cycle_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, per-state timer limit, datapath strobes and state-decoded outputs.
    always_comb begin
        state_next  = state;
        timer_limit = CHECK_CYCLES;
        load_code   = 1'b0;
        advance     = 1'b0;
        enter_pass  = 1'b0;
        enter_fail  = 1'b0;
        lock_done   = 1'b0;
        rx_clear    = 1'b1;
        busy        = 1'b0;
        unlock      = 1'b0;
        fail        = 1'b0;
        locked      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                rx_clear = 1'b0;
                busy     = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (rx_done) begin
                    load_code  = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy        = 1'b1;
                timer_limit = CHECK_CYCLES;
                if (timer_expired) begin
                    if (!sym_match) begin
                        enter_fail = 1'b1;
                        state_next = ST_FAIL;
                    end else if (sym_idx == LAST_SYM) begin
                        enter_pass = 1'b1;
                        state_next = ST_PASS;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_PASS: begin
                unlock      = 1'b1;
                timer_limit = HOLD_CYCLES;
                if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAIL: begin
                fail        = 1'b1;
                timer_limit = HOLD_CYCLES;
                if (timer_expired) begin
                    state_next = (fail_count == MAX_ATTEMPTS) ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                locked      = 1'b1;
                timer_limit = LOCKOUT_CYCLES;
                if (timer_expired) begin
                    lock_done  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Captured code, symbol pointer and the attempt statistics reported outward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q      <= 8'd0;
            sym_idx     <= 2'd0;
            match_count <= 3'd0;
            check_time  <= 32'd0;
            fail_count  <= 2'd0;
        end else begin
            if (load_code) begin
                code_q      <= rx_code;
                sym_idx     <= 2'd0;
                match_count <= 3'd0;
                check_time  <= 32'd0;
            end

            if (state == ST_CHECK) begin
                if (check_time != 32'hFFFF_FFFF) begin
                    check_time <= check_time + 32'd1;
                end
                if (timer_expired && sym_match) begin
                    match_count <= match_count + 3'd1;
                end
                if (advance) begin
                    sym_idx <= sym_idx + 2'd1;
                end
            end

            if (enter_pass || lock_done) begin
                fail_count <= 2'd0;
            end else if (enter_fail && (fail_count != MAX_ATTEMPTS)) begin
                fail_count <= fail_count + 2'd1;
            end
        end
    end

endmodule
